// File: rtl/axi_sram_wr_bridge_if.sv
// AXI write-channel bundle (AW/W/B) between the interconnect and axi_sram_wr_bridge.
interface axi_sram_wr_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
);
    logic [ADDR_W-1:0]   m_awaddr;
    logic [1:0]          m_awburst;
    logic [ID_W-1:0]     m_awid;
    logic [LEN_W-1:0]    m_awlen;
    logic [2:0]          m_awsize;
    logic                m_awvalid;
    logic                m_awready;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wlast;
    logic                m_wvalid;
    logic                m_wready;
    logic [ID_W-1:0]     m_bid;
    logic [1:0]          m_bresp;
    logic                m_bvalid;
    logic                m_bready;

    modport master (
        output m_awaddr, m_awburst, m_awid, m_awlen, m_awsize, m_awvalid,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_bready,
        input  m_awready, m_wready, m_bid, m_bresp, m_bvalid
    );

    modport slave (
        input  m_awaddr, m_awburst, m_awid, m_awlen, m_awsize, m_awvalid,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_bready,
        output m_awready, m_wready, m_bid, m_bresp, m_bvalid
    );
endinterface

// File: rtl/axi_sram_wr_bridge.sv
// One-burst-at-a-time AXI write to single-cycle SRAM bridge: one byte-masked SRAM write per W beat, one B per burst.
// Optional AXI_SRAM_WR_LEN_CHK_EN: burst also ends at awlen and a wlast/length mismatch returns SLVERR.
//
// state | meaning
// IDLE  | awready=1, waiting for a write address
// DATA  | wready=1, each W handshake writes SRAM combinationally
// RESP  | bvalid=1 with latched bid/bresp until bready
module axi_sram_wr_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) (
    input  logic                aclk,
    input  logic                areset,
    axi_sram_wr_bridge_if.slave axi,
    output logic [ADDR_W-1:0]   ram_waddr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wen
);
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ID_W-1:0]   id_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [1:0]        bresp_q;
    logic              aw_hs;
    logic              w_hs;
    logic              burst_end;
    logic              len_err;
    logic [ADDR_W-1:0] addr_step;

    assign aw_hs = (state == IDLE) && axi.m_awvalid;
    assign w_hs  = (state == DATA) && axi.m_wvalid;

`ifdef AXI_SRAM_WR_LEN_CHK_EN
    logic len_hit;
    assign len_hit   = (cnt_q == len_q);
    assign burst_end = axi.m_wlast || len_hit;
    assign len_err   = (axi.m_wlast != len_hit);
`else
    // Length and beat count are kept only for debug visibility in this build.
    logic unused_len;
    assign unused_len = ^{len_q, cnt_q};
    assign burst_end  = axi.m_wlast;
    assign len_err    = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        axi.m_awready = 1'b0;
        axi.m_wready  = 1'b0;
        axi.m_bvalid  = 1'b0;
        case (state)
            IDLE: begin
                axi.m_awready = 1'b1;
                if (axi.m_awvalid) state_nxt = DATA;
            end
            DATA: begin
                axi.m_wready = 1'b1;
                if (axi.m_wvalid && burst_end) state_nxt = RESP;
            end
            RESP: begin
                axi.m_bvalid = 1'b1;
                if (axi.m_bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign addr_step = {{(ADDR_W-1){1'b0}}, 1'b1} << size_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            bresp_q <= 2'b00;
        end else if (aw_hs) begin
            addr_q  <= axi.m_awaddr;
            id_q    <= axi.m_awid;
            len_q   <= axi.m_awlen;
            size_q  <= axi.m_awsize;
            burst_q <= axi.m_awburst;
            cnt_q   <= '0;
            bresp_q <= 2'b00;
        end else if (w_hs) begin
            // WRAP is deliberately handled as INCR; only FIXED holds the address.
            if (burst_q != 2'b00) addr_q <= addr_q + addr_step;
            if (cnt_q != {LEN_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
            if (len_err) bresp_q <= 2'b10;
        end
    end

    assign axi.m_bid   = id_q;
    assign axi.m_bresp = bresp_q;

    assign ram_waddr = addr_q;
    assign ram_wdata = axi.m_wdata;
    assign ram_wen   = w_hs ? axi.m_wstrb : '0;
endmodule

// File: doc/axi_sram_wr_bridge.md
Name: axi_sram_wr_bridge

Overview:
Write-channel counterpart of the AXI-to-SRAM read bridge. Accepts one AXI write burst at a time on AW/W, issues one SRAM byte-masked write per accepted W beat, then returns a single B response. Sits between the AXI interconnect slave port and the write port of the single-cycle on-chip SRAM.

Parameters:
ADDR_W, 32, AXI/SRAM byte-address width
DATA_W, 32, data width; strobe width DATA_W/8
ID_W, 4, AXI ID width
LEN_W, 4, burst length field width (beats = len+1)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
ram_waddr  out  ADDR_W  SRAM byte write address
ram_wdata  out  DATA_W  SRAM write data
ram_wen  out  DATA_W/8  SRAM per-byte write enable; 0 = no write
m_awaddr  in  ADDR_W  burst start address
m_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
m_awid  in  ID_W  transaction ID
m_awlen  in  LEN_W  beats-1
m_awsize  in  3  bytes per beat = 1<<awsize, ≤ DATA_W/8
m_awvalid  in  1  AW valid
m_awready  out  1  AW ready
m_wdata  in  DATA_W  write data
m_wstrb  in  DATA_W/8  byte strobes
m_wlast  in  1  last beat
m_wvalid  in  1  W valid
m_wready  out  1  W ready
m_bid  out  ID_W  response ID (latched awid)
m_bresp  out  2  response, 00 OKAY / 10 SLVERR
m_bvalid  out  1  B valid
m_bready  in  1  B ready

Behaviour:
- Reset (async, immediate): state IDLE; m_awready=1, m_wready=0, m_bvalid=0, m_bid=0, m_bresp=00, ram_wen=0; beat counter and latched address cleared. Reset mid-burst abandons burst, no B issued.
- FSM IDLE -> DATA on awvalid&awready: latch awaddr, awid, awlen, awsize, awburst; clear beat counter; bresp latch=00.
- IDLE: awready=1, wready=0. W beats presented in IDLE (including same cycle as AW) are not accepted.
- DATA: awready=0, wready=1. Per W handshake, same cycle (combinational): ram_wen=m_wstrb, ram_wdata=m_wdata, ram_waddr=current address. Otherwise ram_wen=0; ram_waddr/ram_wdata don't-care.
- Address update after each beat: INCR/WRAP add 1<<awsize, modulo 2^ADDR_W wrap; FIXED holds. Counter increments, saturates at 2^LEN_W-1.
- DATA -> RESP on the W handshake with wlast=1 (burst end rule without macro; beat count not checked).
- RESP: awready=0, wready=0, bvalid=1, bid=latched ID, bresp=latched response; held stable until bready. bvalid&bready -> IDLE; next AW accepted earliest next cycle.
- One transaction outstanding. Min occupancy for N-beat burst with no stalls: 1 AW cycle + N W cycles + 1 B cycle.
- wvalid deasserting mid-burst stalls; no writes on idle cycles. wstrb=0 beat counts as beat, writes no bytes.
- awsize > log2(DATA_W/8) is illegal; behaviour unspecified.

Optional Feature:
AXI_SRAM_WR_LEN_CHK_EN. Defined: burst ends on the W handshake where wlast=1 OR counter==awlen; if wlast != (counter==awlen) on that beat, bresp=10 SLVERR; that beat is still written. Undefined: end on wlast only, bresp always 00, counter only for address debug.

Test Plan:
- Single beat: AW addr 0x100, len 0, size 2, id 3; W 0xDEADBEEF strb F last -> ram_wen=F at addr 0x100 same cycle; B bid=3 bresp=00 one cycle later.
- INCR 4-beat, size 2 at 0x1000, W valid every cycle -> writes at 0x1000/0x1004/0x1008/0x100C, burst done in 6 cycles total, bvalid after 4th beat.
- FIXED 3-beat at 0x20, strb 1/2/4 -> three writes all at 0x20 with ram_wen 1,2,4; awready low until B handshake.
- Backpressure: wvalid gaps and bready held 0 for 5 cycles -> no ram_wen on gap cycles, bvalid/bid/bresp stable, awready=0 throughout, new AW accepted cycle after bready.
- Reset: assert areset after beat 2 of 4 -> ram_wen=0, wready=0, awready=1 immediately; no bvalid after release; fresh 1-beat burst completes OKAY.
- With AXI_SRAM_WR_LEN_CHK_EN: len 3 burst with wlast on beat 2 -> 2 writes, bresp=10; len 1 without wlast -> ends after beat 2, bresp=10; without macro second case stays in DATA.
